// File: rtl/ahb_display_hub_pkg.sv
// Shared AHB-Lite constants, error-response FSM states and the hex glyph decoder
// used by ahb_display_hub and its memory slaves.
package ahb_display_hub_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR_1    = 2'd1,
        ERR_2    = 2'd2
    } err_state_e;

    // Active-high segments ordered {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ahb_display_hub_mem_slave.sv
// Zero-wait memory slave: one write port and a bus read port sharing the latched
// data-phase offset, plus an independent display read port.
module ahb_mem_slave
    import ahb_display_hub_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 16,
    parameter int OFF_W     = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [OFF_W-1:0]  disp_addr_i,
    output logic [DATA_W-1:0] disp_data_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[off_i] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[off_i];
    assign disp_data_o = mem_q[disp_addr_i];

endmodule

// File: rtl/ahb_display_hub.sv
// AHB-Lite hub with NUM_SLAVES memories, confirm-triggered snapshot and a scanned
// hex display. Define AHB_DISPLAY_HUB_ERR_EN for a two-cycle ERROR on unmapped access.
module ahb_display_hub
    import ahb_display_hub_pkg::*;
#(
    parameter  int NUM_SLAVES = 2,
    parameter  int ADDR_W     = 10,
    parameter  int DATA_W     = 8,
    parameter  int MEM_DEPTH  = 16,
    parameter  int SCAN_DIV   = 1000,
    localparam int OFF_W      = $clog2(MEM_DEPTH),
    localparam int DIGITS     = NUM_SLAVES * DATA_W / 4
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic              hresp,
    input  logic [OFF_W-1:0]  disp_addr,
    input  logic              confirm,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en
);

    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SNAP_W = NUM_SLAVES * DATA_W;
`ifdef AHB_DISPLAY_HUB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic [IDX_W-1:0] addr_idx;
    logic             addr_mapped;
    logic             accept;

    logic             dp_valid_q, dp_valid_d;
    logic             dp_write_q, dp_write_d;
    logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
    logic [OFF_W-1:0] dp_off_q, dp_off_d;
    logic             dp_unmapped_q, dp_unmapped_d;
    err_state_e       err_state_q, err_state_d;

    logic [NUM_SLAVES-1:0] slave_we;
    logic [DATA_W-1:0]     rd_data   [NUM_SLAVES];
    logic [DATA_W-1:0]     disp_data [NUM_SLAVES];

    logic              sync1_q, sync2_q, sync_prev_q;
    logic              conf_edge;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [3:0]        cur_nib;

    assign addr_idx    = haddr[ADDR_W-1:OFF_W];
    assign addr_mapped = (int'(addr_idx) < NUM_SLAVES);

    // Bus handshake and error FSM: hready only drops in the first ERROR cycle,
    // so an address phase offered there is never accepted.
    always_comb begin
        hready        = (err_state_q != ERR_1);
        hresp         = (err_state_q == ERR_IDLE) ? HRESP_OKAY : HRESP_ERROR;
        accept        = hready && htrans[1];
        dp_valid_d    = dp_valid_q;
        dp_write_d    = dp_write_q;
        dp_idx_d      = dp_idx_q;
        dp_off_d      = dp_off_q;
        dp_unmapped_d = dp_unmapped_q;
        err_state_d   = err_state_q;
        if (hready) begin
            dp_valid_d    = accept;
            dp_write_d    = hwrite;
            dp_idx_d      = addr_idx;
            dp_off_d      = haddr[OFF_W-1:0];
            dp_unmapped_d = !addr_mapped;
        end
        case (err_state_q)
            ERR_1:   err_state_d = ERR_2;
            default: err_state_d = (ERR_EN && accept && !addr_mapped) ? ERR_1 : ERR_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dp_valid_q    <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_idx_q      <= '0;
            dp_off_q      <= '0;
            dp_unmapped_q <= 1'b0;
            err_state_q   <= ERR_IDLE;
        end else begin
            dp_valid_q    <= dp_valid_d;
            dp_write_q    <= dp_write_d;
            dp_idx_q      <= dp_idx_d;
            dp_off_q      <= dp_off_d;
            dp_unmapped_q <= dp_unmapped_d;
            err_state_q   <= err_state_d;
        end
    end

    always_comb begin
        hrdata   = '0;
        slave_we = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (dp_valid_q && !dp_unmapped_q && (int'(dp_idx_q) == s)) begin
                slave_we[s] = dp_write_q;
                if (!dp_write_q) begin
                    hrdata = rd_data[s];
                end
            end
        end
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
        ahb_mem_slave #(
            .DATA_W    (DATA_W),
            .MEM_DEPTH (MEM_DEPTH),
            .OFF_W     (OFF_W)
        ) u_slave (
            .clk_i       (hclk),
            .rst_i       (hreset),
            .we_i        (slave_we[s]),
            .off_i       (dp_off_q),
            .wdata_i     (hwdata),
            .rdata_o     (rd_data[s]),
            .disp_addr_i (disp_addr),
            .disp_data_o (disp_data[s])
        );
    end

    // The snapshot reads the memories combinationally, so a write committing on
    // the same edge is not yet visible and the pre-write word is captured.
    assign conf_edge = sync2_q && !sync_prev_q;

    always_comb begin
        snap_d = snap_q;
        if (conf_edge) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                snap_d[s*DATA_W +: DATA_W] = disp_data[s];
            end
        end
        cnt_d = cnt_q + 1'b1;
        dig_d = dig_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            snap_q      <= '0;
            cnt_q       <= '0;
            dig_q       <= '0;
        end else begin
            sync1_q     <= confirm;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
        end
    end

    assign cur_nib = 4'(snap_q >> {dig_q, 2'b00});
    assign seg     = hex_to_seg(cur_nib);

    always_comb begin
        dig_en = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_en[k] = (int'(dig_q) == k);
        end
    end

endmodule
